// File: rtl/pack_fifo_pkg.sv
// Shared defaults and width helpers for the lane-packing FIFO.
package pack_fifo_pkg;

  localparam int DEF_IN_W      = 8;
  localparam int DEF_RATIO     = 4;
  localparam int DEF_DEPTH     = 8;
  localparam int DEF_LSB_FIRST = 1;

  // Index/pointer width for a range of n entries (n >= 2).
  function automatic int idx_width(input int n);
    return $clog2(n);
  endfunction

  // Count must also represent the value n itself.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/pack_fifo_ram.sv
// Word storage: one synchronous write port, one asynchronous read port.
module pack_fifo_ram
  import pack_fifo_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int W     = DEF_IN_W * DEF_RATIO + DEF_RATIO
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic [idx_width(DEPTH)-1:0] waddr,
  input  logic [W-1:0]                wdata,
  input  logic [idx_width(DEPTH)-1:0] raddr,
  output logic [W-1:0]                rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pack_fifo.sv
// Packs IN_W-bit lanes into RATIO-lane words with a keep mask, then queues them.
module pack_fifo
  import pack_fifo_pkg::*;
#(
  parameter int IN_W      = DEF_IN_W,
  parameter int RATIO     = DEF_RATIO,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int LSB_FIRST = DEF_LSB_FIRST
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [IN_W-1:0]             in_data,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [IN_W*RATIO-1:0]       out_data,
  output logic [RATIO-1:0]            out_keep,
  output logic                        full,
  output logic                        empty,
  output logic [cnt_width(DEPTH)-1:0] count
);

  localparam int OUT_W  = IN_W * RATIO;
  localparam int LANE_W = idx_width(RATIO);
  localparam int PTR_W  = idx_width(DEPTH);
  localparam int CNT_W  = cnt_width(DEPTH);

  logic [LANE_W-1:0] lane_idx_reg;
  logic [OUT_W-1:0]  partial_data_reg;
  logic [RATIO-1:0]  partial_keep_reg;
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;

  logic [LANE_W-1:0]        lane_pos;
  logic [OUT_W-1:0]         word_next;
  logic [RATIO-1:0]         keep_next;
  logic [OUT_W+RATIO-1:0]   rd_word;
  logic                     accept;
  logic                     close_word;
  logic                     pop;

  assign full      = (count_reg == CNT_W'(DEPTH));
  assign empty     = (count_reg == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign count     = count_reg;

  assign accept     = in_valid && in_ready;
  assign close_word = accept && (in_last || (lane_idx_reg == LANE_W'(RATIO - 1)));
  assign pop        = out_valid && out_ready;

  // Physical lane that the current logical index maps to.
  assign lane_pos = (LSB_FIRST != 0) ? lane_idx_reg
                                     : LANE_W'(RATIO - 1) - lane_idx_reg;

  for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
    assign word_next[gi*IN_W +: IN_W] = (lane_pos == LANE_W'(gi)) ? in_data
                                                                : partial_data_reg[gi*IN_W +: IN_W];
    assign keep_next[gi] = (lane_pos == LANE_W'(gi)) || partial_keep_reg[gi];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_idx_reg     <= '0;
      partial_data_reg <= '0;
      partial_keep_reg <= '0;
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
    end else begin
      if (close_word) begin
        // Clearing the partial word keeps unwritten lanes of the next word at zero.
        lane_idx_reg     <= '0;
        partial_data_reg <= '0;
        partial_keep_reg <= '0;
        wr_ptr_reg       <= wr_ptr_reg + PTR_W'(1);
      end else if (accept) begin
        lane_idx_reg     <= lane_idx_reg + LANE_W'(1);
        partial_data_reg <= word_next;
        partial_keep_reg <= keep_next;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({close_word, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  pack_fifo_ram #(
    .DEPTH (DEPTH),
    .W     (OUT_W + RATIO)
  ) u_ram (
    .clk   (clk),
    .we    (close_word),
    .waddr (wr_ptr_reg),
    .wdata ({keep_next, word_next}),
    .raddr (rd_ptr_reg),
    .rdata (rd_word)
  );

  // Stale storage contents never leak out while nothing is stored.
  assign out_data = empty ? '0 : rd_word[OUT_W-1:0];
  assign out_keep = empty ? '0 : rd_word[OUT_W +: RATIO];

endmodule

// File: tb/tb_pack_fifo.sv
// Randomised and directed checks of pack_fifo against a queue-based word model.
module tb_pack_fifo;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        full;
  logic        empty;
  logic [3:0]  count;

  logic        m_in_valid = 1'b0;
  logic        m_in_ready;
  logic [7:0]  m_in_data = '0;
  logic        m_in_last = 1'b0;
  logic        m_out_valid;
  logic        m_out_ready = 1'b0;
  logic [31:0] m_out_data;
  logic [3:0]  m_out_keep;
  logic        m_full;
  logic        m_empty;
  logic [3:0]  m_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pack_fifo dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_keep(out_keep),
    .full(full), .empty(empty), .count(count)
  );

  pack_fifo #(.LSB_FIRST(0)) dut_msb (
    .clk(clk), .rst(rst), .in_valid(m_in_valid), .in_ready(m_in_ready),
    .in_data(m_in_data), .in_last(m_in_last), .out_valid(m_out_valid),
    .out_ready(m_out_ready), .out_data(m_out_data), .out_keep(m_out_keep),
    .full(m_full), .empty(m_empty), .count(m_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of finished words plus the word being assembled.
  logic [31:0] mq_data[$];
  logic [3:0]  mq_keep[$];
  int          m_lanes = 0;
  logic [31:0] m_word = '0;
  logic [3:0]  m_kmask = '0;
  bit          m_acc;
  bit          m_pop;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      mq_data.delete();
      mq_keep.delete();
      m_lanes = 0;
      m_word  = '0;
      m_kmask = '0;
    end else begin
      m_acc = in_valid && (mq_data.size() < DEPTH);
      m_pop = out_ready && (mq_data.size() > 0);
      if (m_pop) begin
        void'(mq_data.pop_front());
        void'(mq_keep.pop_front());
      end
      if (m_acc) begin
        m_word  = m_word | (32'(in_data) << (8 * m_lanes));
        m_kmask = m_kmask | (4'b1 << m_lanes);
        m_lanes++;
        if (m_lanes == 4 || in_last) begin
          mq_data.push_back(m_word);
          mq_keep.push_back(m_kmask);
          m_lanes = 0;
          m_word  = '0;
          m_kmask = '0;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    chk("count", 64'(count), 64'(mq_data.size()));
    chk("empty", 64'(empty), 64'(mq_data.size() == 0));
    chk("full", 64'(full), 64'(mq_data.size() == DEPTH));
    chk("out_valid", 64'(out_valid), 64'(mq_data.size() != 0));
    chk("in_ready", 64'(in_ready), 64'(mq_data.size() != DEPTH));
    if (mq_data.size() != 0) begin
      chk("out_data", 64'(out_data), 64'(mq_data[0]));
      chk("out_keep", 64'(out_keep), 64'(mq_keep[0]));
    end else begin
      chk("out_data_masked", 64'(out_data), 64'd0);
      chk("out_keep_masked", 64'(out_keep), 64'd0);
    end
  end

  task automatic send_lane(input logic [7:0] d, input logic last);
    int waited;
    waited = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready) begin
      if (waited == 200) begin
        chk("send_timeout", 64'd1, 64'd0);
        in_valid = 1'b0;
        in_last  = 1'b0;
        return;
      end
      @(posedge clk); #1;
      waited++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    out_ready = 1'b1;
    while (!empty) begin
      if (waited == 200) begin
        chk("drain_timeout", 64'd1, 64'd0);
        break;
      end
      @(posedge clk); #1;
      waited++;
    end
    out_ready = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_keep", 64'(out_keep), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // MSB-first packing on the second instance.
    m_in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      m_in_data = 8'(i);
      @(posedge clk); #1;
    end
    m_in_valid = 1'b0;
    chk("msb_first_data", 64'(m_out_data), 64'h01020304);
    chk("msb_first_keep", 64'(m_out_keep), 64'hF);

    // Back-to-back full words with the consumer always ready.
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) send_lane(8'(i), 1'b0);
    chk("word1_valid", 64'(out_valid), 64'd1);
    chk("word1_data", 64'(out_data), 64'h04030201);
    chk("word1_keep", 64'(out_keep), 64'hF);
    for (int i = 5; i <= 8; i++) send_lane(8'(i), 1'b0);
    chk("word2_data", 64'(out_data), 64'h08070605);
    chk("word2_keep", 64'(out_keep), 64'hF);

    // Early close with in_last, then the next lane starts at lane 0.
    send_lane(8'hAA, 1'b0);
    send_lane(8'hBB, 1'b1);
    chk("last_data", 64'(out_data), 64'h0000BBAA);
    chk("last_keep", 64'(out_keep), 64'h3);
    send_lane(8'hCC, 1'b1);
    chk("after_last_data", 64'(out_data), 64'h000000CC);
    chk("after_last_keep", 64'(out_keep), 64'h1);
    drain();

    // Fill to full with the consumer stalled.
    for (int i = 0; i < 32; i++) send_lane(8'(i + 8'h40), 1'b0);
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_in_ready", 64'(in_ready), 64'd0);
    chk("fill_count", 64'(count), 64'd8);
    in_valid = 1'b1;
    in_data  = 8'h33;
    repeat (3) begin @(posedge clk); #1; end
    chk("held_count", 64'(count), 64'd8);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("pop_count", 64'(count), 64'd7);
    chk("pop_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("partial_not_counted", 64'(count), 64'd7);
    for (int i = 0; i < 3; i++) send_lane(8'(i + 8'h34), 1'b0);
    drain();

    // Full-rate streaming across many pointer wraps.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 80; i++) begin
      in_data = 8'(i + 8'h80);
      @(posedge clk); #1;
      if (count > 4'd1) chk("stream_count_bound", 64'(count), 64'd1);
    end
    in_valid = 1'b0;
    drain();

    // Reset with stored words and a partial word outstanding.
    for (int i = 0; i < 14; i++) send_lane(8'(i + 8'h60), 1'b0);
    chk("prerst_count", 64'(count), 64'd3);
    rst = 1'b1;
    #1;
    chk("midrst_empty", 64'(empty), 64'd1);
    chk("midrst_count", 64'(count), 64'd0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_data", 64'(out_data), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) send_lane(8'(8'h11 + i), 1'b0);
    chk("postrst_data", 64'(out_data), 64'h14131211);
    chk("postrst_keep", 64'(out_keep), 64'hF);
    drain();

    // Random traffic: stall-heavy, then drain-heavy.
    for (int phase = 0; phase < 2; phase++) begin
      for (int c = 0; c < 1500; c++) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        in_data   = 8'($urandom);
        in_last   = ($urandom_range(0, 7) == 0);
        out_ready = (phase == 0) ? ($urandom_range(0, 3) == 0)
                                 : ($urandom_range(0, 3) != 0);
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    drain();
    @(negedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
